enum_pair_receiver: RTL and testbench

Consumer-side counterpart to the enum-pair driver in the test package. It accepts pairs of `kind_t` / `mode_t` encoded values over a valid/ready handshake and holds each pair in a single-entry output register. It classifies each pair as legal or illegal, emits a one-hot pair class, and keeps saturating statistics. It sits between any block producing the two enum fields and downstream logic that needs only legal, decoded codes.

---
 rtl/enum_pair_receiver.sv | 173 +++++++++++++++++
 tb/tb_enum_pair_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/enum_pair_receiver.sv
// Enum-pair receiver: accepts kind/mode pairs over valid/ready, holds one
// classified pair for downstream and keeps saturating legal/illegal statistics.

package enum_rx_pkg;

  typedef enum logic [1:0] {
    KIND_A = 2'b00,
    KIND_B = 2'b01
  } kind_t;

  typedef enum logic [2:0] {
    MODE_A = 3'b000,
    MODE_C = 3'b010
  } mode_t;

endpackage : enum_rx_pkg

module enum_pair_receiver
  import enum_rx_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_class,
  output logic             out_err,
  output logic             sticky_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err,
  input  logic             clr
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] cls;
  } pair_res_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic kind_legal(input logic [1:0] kind);
    logic ok;
    ok = 1'b0;
    if (kind == KIND_A || kind == KIND_B) begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic mode_legal(input logic [2:0] mode);
    logic ok;
    ok = 1'b0;
    if (mode == MODE_A || mode == MODE_C) begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  // Any illegal field collapses the class to zero and flags the pair.
  function automatic pair_res_t classify(input logic [1:0] kind,
                                         input logic [2:0] mode);
    pair_res_t res;
    res.err = 1'b1;
    res.cls = 4'b0000;
    if (kind_legal(kind) && mode_legal(mode)) begin
      res.err = 1'b0;
      if (kind == KIND_A && mode == MODE_A) begin
        res.cls = 4'b0001;
      end else if (kind == KIND_A && mode == MODE_C) begin
        res.cls = 4'b0010;
      end else if (kind == KIND_B && mode == MODE_A) begin
        res.cls = 4'b0100;
      end else begin
        res.cls = 4'b1000;
      end
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] nxt;
    if (&val) begin
      nxt = val;
    end else begin
      nxt = val + CNT_ONE;
    end
    return nxt;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       class_q, class_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

  logic      accept;
  pair_res_t in_res;

  assign in_ready = (state_q == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_res   = classify(in_kind, in_mode);

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    err_d     = err_q;
    sticky_d  = sticky_q;
    cnt_ok_d  = cnt_ok_q;
    cnt_err_d = cnt_err_q;

    // A fill reloads the holding register; a drain without fill empties it.
    if (accept) begin
      state_d = FULL;
      class_d = in_res.cls;
      err_d   = in_res.err;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end

    if (accept) begin
      if (in_res.err) begin
        cnt_err_d = sat_inc(cnt_err_q);
        sticky_d  = 1'b1;
      end else begin
        cnt_ok_d = sat_inc(cnt_ok_q);
      end
    end

    // Clear wins over any increment landing in the same cycle.
    if (clr) begin
      cnt_ok_d  = '0;
      cnt_err_d = '0;
      sticky_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      class_q   <= 4'b0000;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      cnt_ok_q  <= cnt_ok_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_class  = class_q;
  assign out_err    = err_q;
  assign sticky_err = sticky_q;
  assign cnt_ok     = cnt_ok_q;
  assign cnt_err    = cnt_err_q;

endmodule : enum_pair_receiver

// File: tb/tb_enum_pair_receiver.sv
// Scoreboard bench for enum_pair_receiver: a wide-counter instance plus a
// CNT_W=2 instance sharing the same stimulus for saturation behaviour.

module tb_enum_pair_receiver;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_kind;
  logic [2:0] in_mode;
  logic       out_ready;
  logic       clr;

  logic       in_ready, out_valid, out_err, sticky_err;
  logic [3:0] out_class;
  logic [7:0] cnt_ok, cnt_err;

  logic       s_in_ready, s_out_valid, s_out_err, s_sticky_err;
  logic [3:0] s_out_class;
  logic [1:0] s_cnt_ok, s_cnt_err;

  int n_checks = 0;
  int n_err    = 0;

  logic [4:0] sb[$];
  logic       exp_full;
  logic       exp_sticky;
  int         exp_ok, exp_errc, exp_ok2, exp_errc2;

  enum_pair_receiver #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err),
    .sticky_err(sticky_err), .cnt_ok(cnt_ok), .cnt_err(cnt_err),
    .clr(clr)
  );

  enum_pair_receiver #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_kind(in_kind), .in_mode(in_mode),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_class(s_out_class), .out_err(s_out_err),
    .sticky_err(s_sticky_err), .cnt_ok(s_cnt_ok), .cnt_err(s_cnt_err),
    .clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {err, class}: legal iff kind[1]==0 and mode in {000,010}.
  function automatic logic [4:0] model_cls(input logic [1:0] k, input logic [2:0] m);
    logic [3:0] one;
    if (k[1] || m[0] || m[2]) return 5'b1_0000;
    one = 4'b0001 << {k[0], m[1]};
    return {1'b0, one};
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Reference model and output scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic       acc;
    logic [4:0] e;
    if (!rst_n) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_class", {28'd0, out_class}, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
      chk("rst_sticky", {31'd0, sticky_err}, 32'd0);
      chk("rst_cnt_ok", {24'd0, cnt_ok}, 32'd0);
      chk("rst_cnt_err", {24'd0, cnt_err}, 32'd0);
      chk("rst_sat_cnt_ok", {30'd0, s_cnt_ok}, 32'd0);
      exp_full   = 1'b0;
      exp_sticky = 1'b0;
      exp_ok = 0; exp_errc = 0; exp_ok2 = 0; exp_errc2 = 0;
      sb.delete();
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_full});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!exp_full || out_ready)});
      chk("sat_in_ready", {31'd0, s_in_ready}, {31'd0, (!exp_full || out_ready)});
      chk("cnt_ok", {24'd0, cnt_ok}, exp_ok);
      chk("cnt_err", {24'd0, cnt_err}, exp_errc);
      chk("sat_cnt_ok", {30'd0, s_cnt_ok}, exp_ok2);
      chk("sat_cnt_err", {30'd0, s_cnt_err}, exp_errc2);
      chk("sticky_err", {31'd0, sticky_err}, {31'd0, exp_sticky});
      if (exp_full) begin
        chk("sb_depth", sb.size(), 32'd1);
        if (sb.size() > 0) begin
          chk("held_pair", {27'd0, out_err, out_class}, {27'd0, sb[0]});
          chk("sat_held_pair", {27'd0, s_out_err, s_out_class}, {27'd0, sb[0]});
          if (out_ready) void'(sb.pop_front());
        end
      end
      acc = in_valid && (!exp_full || out_ready);
      e   = model_cls(in_kind, in_mode);
      if (acc) sb.push_back(e);
      if (clr) begin
        exp_ok = 0; exp_errc = 0; exp_ok2 = 0; exp_errc2 = 0;
        exp_sticky = 1'b0;
      end else if (acc) begin
        if (e[4]) begin
          exp_errc   = sat(exp_errc, 255);
          exp_errc2  = sat(exp_errc2, 3);
          exp_sticky = 1'b1;
        end else begin
          exp_ok  = sat(exp_ok, 255);
          exp_ok2 = sat(exp_ok2, 3);
        end
      end
      exp_full = acc ? 1'b1 : (exp_full && !out_ready);
    end
  end

  task automatic cyc(input logic v, input logic [1:0] k, input logic [2:0] m,
                     input logic ordy, input logic c);
    in_valid  = v;
    in_kind   = k;
    in_mode   = m;
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_kind = 2'b00; in_mode = 3'b000;
    out_ready = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Legal stream at full throughput
    cyc(1, 2'b00, 3'b000, 1, 0);
    cyc(1, 2'b00, 3'b010, 1, 0);
    cyc(1, 2'b01, 3'b000, 1, 0);
    cyc(1, 2'b01, 3'b010, 1, 0);
    cyc(0, 2'b00, 3'b000, 1, 0);
    chk("legal_cnt_ok", {24'd0, cnt_ok}, 32'd4);
    chk("legal_cnt_err", {24'd0, cnt_err}, 32'd0);

    // Backpressure with same-cycle drain and reload
    cyc(0, 2'b00, 3'b000, 1, 1);
    cyc(1, 2'b01, 3'b010, 1, 0);
    repeat (3) cyc(1, 2'b00, 3'b000, 0, 0);
    chk("bp_hold_class", {28'd0, out_class}, 32'h8);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(1, 2'b00, 3'b000, 1, 0);
    chk("bp_reload_class", {28'd0, out_class}, 32'h1);
    cyc(0, 2'b00, 3'b000, 1, 0);
    chk("bp_cnt_ok", {24'd0, cnt_ok}, 32'd2);

    // Illegal encodings
    cyc(1, 2'b10, 3'b000, 1, 0);
    chk("ill_kind_err", {27'd0, out_err, out_class}, 32'h10);
    cyc(1, 2'b00, 3'b111, 1, 0);
    chk("ill_mode_err", {27'd0, out_err, out_class}, 32'h10);
    cyc(0, 2'b00, 3'b000, 1, 0);
    chk("ill_cnt_err", {24'd0, cnt_err}, 32'd2);
    chk("ill_sticky", {31'd0, sticky_err}, 32'd1);

    // Clear colliding with an illegal accept
    cyc(1, 2'b11, 3'b101, 0, 1);
    chk("clr_held_err", {31'd0, out_err}, 32'd1);
    chk("clr_cnt_err", {24'd0, cnt_err}, 32'd0);
    chk("clr_sticky", {31'd0, sticky_err}, 32'd0);
    cyc(0, 2'b00, 3'b000, 1, 0);

    // Saturation of the narrow counter
    cyc(0, 2'b00, 3'b000, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, {1'b0, i[0]}, {1'b0, i[1], 1'b0}, 1, 0);
    end
    cyc(0, 2'b00, 3'b000, 1, 0);
    chk("sat_cnt_ok_cap", {30'd0, s_cnt_ok}, 32'd3);
    chk("wide_cnt_ok", {24'd0, cnt_ok}, 32'd5);

    // Asynchronous reset while holding a pair
    cyc(1, 2'b00, 3'b010, 0, 0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_cnt_ok", {24'd0, cnt_ok}, 32'd0);
    chk("arst_out_class", {28'd0, out_class}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    cyc(1, 2'b01, 3'b000, 1, 0);
    chk("post_rst_class", {28'd0, out_class}, 32'h4);
    chk("post_rst_cnt_ok", {24'd0, cnt_ok}, 32'd1);
    cyc(0, 2'b00, 3'b000, 1, 0);
    cyc(0, 2'b00, 3'b000, 1, 0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_enum_pair_receiver
